ethernet_system_descriptor_arbiter: RTL and testbench



---
 rtl/ethernet_system_desc_pkg.sv | 19 +
 rtl/ethernet_system_rr_grant.sv | 56 +++++
 rtl/ethernet_system_descriptor_arbiter.sv | 118 +++++++++++
 tb/tb_ethernet_system_descriptor_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ethernet_system_desc_pkg.sv
// Shared widths, requester ids and grant-state layout for the SGDMA descriptor RAM arbiter.
package ethernet_system_desc_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic {
    REQ_TX = 1'b0,
    REQ_RX = 1'b1
  } req_id_e;

  typedef struct packed {
    req_id_e last_grant;
    logic    lock_valid;
    req_id_e lock_owner;
  } grant_state_t;

endpackage

// File: rtl/ethernet_system_rr_grant.sv
// Two-way round-robin grant with an owner lock; at most one requester wins per cycle.
module ethernet_system_rr_grant
  import ethernet_system_desc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] active,
  input  logic [1:0] lock,
  output logic [1:0] grant,
  output req_id_e    grant_id
);

  grant_state_t state_q, state_d;
  logic         any_grant;
  logic         sel_lock;

  // A held lock excludes the other requester even when the owner is idle.
  always_comb begin
    grant = 2'b00;
    if (state_q.lock_valid) begin
      if (state_q.lock_owner == REQ_TX) grant[0] = active[0];
      else                              grant[1] = active[1];
    end else if (active == 2'b11) begin
      grant = (state_q.last_grant == REQ_TX) ? 2'b10 : 2'b01;
    end else begin
      grant = active;
    end
    if (reset) grant = 2'b00;
  end

  assign grant_id  = grant[1] ? REQ_RX : REQ_TX;
  assign any_grant = |grant;
  assign sel_lock  = grant[1] ? lock[1] : lock[0];

  always_comb begin
    state_d = state_q;
    if (any_grant) begin
      state_d.last_grant = grant_id;
      if (sel_lock) begin
        state_d.lock_valid = 1'b1;
        state_d.lock_owner = grant_id;
      end else begin
        state_d.lock_valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '{last_grant: REQ_RX, lock_valid: 1'b0, lock_owner: REQ_TX};
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/ethernet_system_descriptor_arbiter.sv
// Shares one descriptor RAM port between the TX (m0) and RX (m1) chain engines,
// muxing the granted request onto the RAM and steering the one-cycle read return.
module ethernet_system_descriptor_arbiter
  import ethernet_system_desc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [BE_W-1:0]   mem_byteenable,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic [1:0]        active;
  logic [1:0]        grant;
  req_id_e           grant_id;
  logic              any_grant;
  logic [ADDR_W-1:0] sel_address;
  logic [DATA_W-1:0] sel_writedata;
  logic [BE_W-1:0]   sel_byteenable;
  logic              sel_write;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              rd_valid_q, rd_valid_d;
  req_id_e           rd_id_q, rd_id_d;

  assign active = {m1_read | m1_write, m0_read | m0_write};

  ethernet_system_rr_grant u_grant (
    .clk      (clk),
    .reset    (reset),
    .active   (active),
    .lock     ({m1_lock, m0_lock}),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign any_grant = |grant;

  always_comb begin
    sel_address    = m0_address;
    sel_writedata  = m0_writedata;
    sel_byteenable = m0_byteenable;
    sel_write      = m0_write;
    if (grant[1]) begin
      sel_address    = m1_address;
      sel_writedata  = m1_writedata;
      sel_byteenable = m1_byteenable;
      sel_write      = m1_write;
    end
  end

  // Idle cycles replay the last granted address/data so the RAM pins stay quiet.
  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rd_valid_d = any_grant & ~sel_write;
    rd_id_d    = grant_id;
    if (any_grant) begin
      addr_d  = sel_address;
      wdata_d = sel_writedata;
      be_d    = sel_byteenable;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= REQ_TX;
    end else begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
    end
  end

  assign mem_chipselect = any_grant;
  assign mem_write      = any_grant & sel_write;
  assign mem_address    = addr_d;
  assign mem_writedata  = wdata_d;
  assign mem_byteenable = be_d;

  assign m0_waitrequest = reset | (active[0] & ~grant[0]);
  assign m1_waitrequest = reset | (active[1] & ~grant[1]);

  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_valid_q & (rd_id_q == REQ_TX);
  assign m1_readdatavalid = rd_valid_q & (rd_id_q == REQ_RX);

endmodule

// File: tb/tb_ethernet_system_descriptor_arbiter.sv
// Directed bench for the descriptor arbiter with a byte-lane RAM model behind the mem port.
module tb_ethernet_system_descriptor_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] m0_address = '0, m1_address = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m0_lock = 1'b0;
  logic        m1_read = 1'b0, m1_write = 1'b0, m1_lock = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_waitrequest, m1_waitrequest;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [10:0] mem_address;
  logic        mem_chipselect, mem_write;
  logic [31:0] mem_writedata, mem_readdata;
  logic [3:0]  mem_byteenable;

  logic [31:0] ram [0:2047];
  logic [31:0] rd_q = '0;

  int errorCount = 0;
  int checkCount = 0;
  int illegalCount = 0;

  ethernet_system_descriptor_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_byteenable    (m0_byteenable),
    .m0_lock          (m0_lock),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_byteenable    (m1_byteenable),
    .m1_lock          (m1_lock),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_byteenable   (mem_byteenable),
    .mem_readdata     (mem_readdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after the address is presented.
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        rd_q <= ram[mem_address];
      end
    end
  end
  assign mem_readdata = rd_q;

  // A requester raising read and write together is an engine protocol error.
  always @(negedge clk) begin
    if (!reset && ((m0_read && m0_write) || (m1_read && m1_write))) begin
      illegalCount++;
      $display("[TB] protocol error: read and write both high at %0t", $time);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int who, input logic rd, input logic wr, input logic [10:0] addr,
                               input logic [31:0] data, input logic [3:0] be, input logic lk);
    if (who == 0) begin
      m0_read = rd; m0_write = wr; m0_address = addr; m0_writedata = data; m0_byteenable = be; m0_lock = lk;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = addr; m1_writedata = data; m1_byteenable = be; m1_lock = lk;
    end
  endtask

  task automatic stepCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idleBoth;
    applyStimulus(0, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic writeWord(input logic [10:0] addr, input logic [31:0] data);
    applyStimulus(0, 1'b0, 1'b1, addr, data, 4'hF, 1'b0);
    stepCycle();
    idleBoth();
    stepCycle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int v0, v1, g, prev;

    // Reset state
    @(negedge clk);
    checkOutput("rst_wr0", m0_waitrequest, 1);
    checkOutput("rst_wr1", m1_waitrequest, 1);
    checkOutput("rst_cs", mem_chipselect, 0);
    checkOutput("rst_rdv0", m0_readdatavalid, 0);
    checkOutput("rst_rdv1", m1_readdatavalid, 0);
    stepCycle();
    reset = 1'b0;
    stepCycle();

    // Single write then read on m0
    applyStimulus(0, 1'b0, 1'b1, 11'h010, 32'hDEADBEEF, 4'hF, 1'b0);
    @(negedge clk);
    checkOutput("t1_cs", mem_chipselect, 1);
    checkOutput("t1_we", mem_write, 1);
    checkOutput("t1_addr", mem_address, 32'h010);
    checkOutput("t1_wdata", mem_writedata, 32'hDEADBEEF);
    checkOutput("t1_wr0", m0_waitrequest, 0);
    stepCycle();
    applyStimulus(0, 1'b1, 1'b0, 11'h010, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    checkOutput("t1_rd_we", mem_write, 0);
    checkOutput("t1_rd_cs", mem_chipselect, 1);
    checkOutput("t1_rd_rdv0", m0_readdatavalid, 0);
    stepCycle();
    idleBoth();
    @(negedge clk);
    checkOutput("t1_rdv0", m0_readdatavalid, 1);
    checkOutput("t1_rdata", m0_readdata, 32'hDEADBEEF);
    checkOutput("t1_rdv1", m1_readdatavalid, 0);
    checkOutput("t1_idle_cs", mem_chipselect, 0);
    checkOutput("t1_idle_we", mem_write, 0);
    checkOutput("t1_idle_addr", mem_address, 32'h010);
    checkOutput("t1_idle_wr1", m1_waitrequest, 0);
    stepCycle();

    writeWord(11'h100, 32'hA5A50100);
    writeWord(11'h200, 32'h5A5A0200);
    writeWord(11'h7FF, 32'h0BADF00D);

    // Both read continuously; m0 won last, so m1 takes the first tie
    applyStimulus(0, 1'b1, 1'b0, 11'h100, 32'h0, 4'hF, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 11'h200, 32'h0, 4'hF, 1'b0);
    v0 = 0; v1 = 0; prev = -1;
    for (int i = 0; i < 8; i++) begin
      g = (i % 2 == 0) ? 1 : 0;
      @(negedge clk);
      checkOutput("alt_wr0", m0_waitrequest, g == 1);
      checkOutput("alt_wr1", m1_waitrequest, g == 0);
      checkOutput("alt_rdv0", m0_readdatavalid, prev == 0);
      checkOutput("alt_rdv1", m1_readdatavalid, prev == 1);
      if (m0_readdatavalid) begin v0++; checkOutput("alt_rdata0", m0_readdata, 32'hA5A50100); end
      if (m1_readdatavalid) begin v1++; checkOutput("alt_rdata1", m1_readdata, 32'h5A5A0200); end
      prev = g;
      stepCycle();
    end
    idleBoth();
    @(negedge clk);
    checkOutput("alt_last_rdv0", m0_readdatavalid, 1);
    if (m0_readdatavalid) v0++;
    checkOutput("alt_cnt0", v0, 4);
    checkOutput("alt_cnt1", v1, 4);
    stepCycle();

    // Lock: m1 holds the port across its read, an idle cycle and its unlocking write
    applyStimulus(0, 1'b1, 1'b0, 11'h100, 32'h0, 4'hF, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 11'h7FF, 32'h0, 4'hF, 1'b1);
    @(negedge clk);
    checkOutput("lk_a_wr0", m0_waitrequest, 1);
    checkOutput("lk_a_wr1", m1_waitrequest, 0);
    stepCycle();
    applyStimulus(1, 1'b0, 1'b0, 11'h7FF, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    checkOutput("lk_idle_wr0", m0_waitrequest, 1);
    checkOutput("lk_idle_cs", mem_chipselect, 0);
    checkOutput("lk_rdv1", m1_readdatavalid, 1);
    checkOutput("lk_rdata1", m1_readdata, 32'h0BADF00D);
    stepCycle();
    applyStimulus(1, 1'b0, 1'b1, 11'h7FF, 32'h55AA55AA, 4'hF, 1'b0);
    @(negedge clk);
    checkOutput("lk_b_wr0", m0_waitrequest, 1);
    checkOutput("lk_b_wr1", m1_waitrequest, 0);
    checkOutput("lk_b_we", mem_write, 1);
    stepCycle();
    applyStimulus(1, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("lk_c_wr0", m0_waitrequest, 0);
    checkOutput("lk_c_addr", mem_address, 32'h100);
    stepCycle();
    idleBoth();
    stepCycle();

    // Partial byteenable merge
    writeWord(11'h020, 32'hFFFFFFFF);
    applyStimulus(0, 1'b0, 1'b1, 11'h020, 32'h12345678, 4'h3, 1'b0);
    @(negedge clk);
    checkOutput("be_lanes", mem_byteenable, 32'h3);
    stepCycle();
    applyStimulus(0, 1'b1, 1'b0, 11'h020, 32'h0, 4'hF, 1'b0);
    stepCycle();
    idleBoth();
    @(negedge clk);
    checkOutput("be_rdv0", m0_readdatavalid, 1);
    checkOutput("be_rdata", m0_readdata, 32'hFFFF5678);
    stepCycle();

    // Reset lands right after a granted m0 read
    applyStimulus(0, 1'b1, 1'b0, 11'h010, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    checkOutput("rr_grant0", m0_waitrequest, 0);
    stepCycle();
    reset = 1'b1;
    applyStimulus(1, 1'b1, 1'b0, 11'h200, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    checkOutput("rr_rdv0", m0_readdatavalid, 0);
    checkOutput("rr_wr0", m0_waitrequest, 1);
    checkOutput("rr_wr1", m1_waitrequest, 1);
    checkOutput("rr_cs", mem_chipselect, 0);
    checkOutput("rr_we", mem_write, 0);
    stepCycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rr_first_wr0", m0_waitrequest, 0);
    checkOutput("rr_first_wr1", m1_waitrequest, 1);
    checkOutput("rr_dropped_rdv0", m0_readdatavalid, 0);
    stepCycle();
    @(negedge clk);
    checkOutput("rr_next_rdv0", m0_readdatavalid, 1);
    checkOutput("rr_next_rdata0", m0_readdata, 32'hDEADBEEF);
    checkOutput("rr_next_wr1", m1_waitrequest, 0);
    stepCycle();
    idleBoth();
    stepCycle();

    // Read and write together is taken as a write
    applyStimulus(0, 1'b1, 1'b1, 11'h030, 32'h11112222, 4'hF, 1'b0);
    @(negedge clk);
    checkOutput("rw_we", mem_write, 1);
    checkOutput("rw_cs", mem_chipselect, 1);
    stepCycle();
    idleBoth();
    @(negedge clk);
    checkOutput("rw_rdv0", m0_readdatavalid, 0);
    checkOutput("rw_flagged", illegalCount, 1);
    stepCycle();
    applyStimulus(0, 1'b1, 1'b0, 11'h030, 32'h0, 4'hF, 1'b0);
    stepCycle();
    idleBoth();
    @(negedge clk);
    checkOutput("rw_readback", m0_readdata, 32'h11112222);
    stepCycle();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
